// File: rtl/conv_mem_pkg.sv
// Shared definitions for the convolution engine's image-RAM access path:
// RAM `we` encodings, the access-master state set and the pixel size.
package conv_mem_pkg;

    localparam logic [1:0] WE_IDLE  = 2'b00;
    localparam logic [1:0] WE_READ  = 2'b01;
    localparam logic [1:0] WE_WRITE = 2'b10;

    localparam int PIXEL_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_GAP,
        WR_B0,
        WR_B1,
        WR_B2,
        RSP
    } state_t;

endpackage

// File: rtl/ram_access_master.sv
// Initiator for the byte-wide image RAM: turns pixel read/write commands into
// cycle-accurate RAM pin sequences and returns data or completion on a response channel.
module ram_access_master
    import conv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 24,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic                  cmd_len3,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_data_in,
    output logic [1:0]            ram_we,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  ram_ready,
    output logic                  err_sticky
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    generate
        if (DATA_WIDTH != PIXEL_BYTES * 8) begin : g_width_check
            $error("ram_access_master: DATA_WIDTH must be 24 (three bytes)");
        end
    endgenerate

    state_t                  state_reg,       state_next;
    logic [CNT_W-1:0]        cnt_reg,         cnt_next;
    logic [ADDR_WIDTH-1:0]   base_reg,        base_next;
    logic [DATA_WIDTH-1:8]   wdata_hi_reg,    wdata_hi_next;
    logic                    len3_reg,        len3_next;
    logic                    cmd_ready_reg,   cmd_ready_next;
    logic                    rsp_valid_reg,   rsp_valid_next;
    logic [DATA_WIDTH-1:0]   rsp_data_reg,    rsp_data_next;
    logic                    rsp_err_reg,     rsp_err_next;
    logic [ADDR_WIDTH-1:0]   ram_addr_reg,    ram_addr_next;
    logic [7:0]              ram_data_in_reg, ram_data_in_next;
    logic [1:0]              ram_we_reg,      ram_we_next;
    logic                    err_sticky_reg,  err_sticky_next;

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        base_next        = base_reg;
        wdata_hi_next    = wdata_hi_reg;
        len3_next        = len3_reg;
        cmd_ready_next   = 1'b0;
        rsp_valid_next   = 1'b0;
        rsp_data_next    = rsp_data_reg;
        rsp_err_next     = rsp_err_reg;
        ram_addr_next    = ram_addr_reg;
        ram_data_in_next = 8'h00;
        ram_we_next      = WE_IDLE;
        err_sticky_next  = err_sticky_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    base_next     = cmd_addr;
                    wdata_hi_next = cmd_wdata[DATA_WIDTH-1:8];
                    len3_next     = cmd_len3;
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b0;
                    ram_addr_next = cmd_addr;
                    cnt_next      = '0;
                    if (cmd_write) begin
                        state_next       = WR_B0;
                        ram_we_next      = WE_WRITE;
                        ram_data_in_next = cmd_wdata[7:0];
                    end else begin
                        state_next  = RD_WAIT;
                        ram_we_next = WE_READ;
                    end
                end else begin
                    cmd_ready_next = 1'b1;
                end
            end

            // `we` stays READ through the cycle ready is seen so the RAM can
            // finish its own return-to-idle step; ready takes priority over timeout.
            RD_WAIT: begin
                if (ram_ready) begin
                    rsp_data_next = ram_data_out;
                    state_next    = RD_GAP;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_next   = '0;
                    rsp_err_next    = 1'b1;
                    err_sticky_next = 1'b1;
                    state_next      = RD_GAP;
                end else begin
                    cnt_next    = cnt_reg + 1'b1;
                    ram_we_next = WE_READ;
                end
            end

            RD_GAP: begin
                state_next     = RSP;
                rsp_valid_next = 1'b1;
            end

            WR_B0: begin
                if (len3_reg) begin
                    state_next       = WR_B1;
                    ram_we_next      = WE_WRITE;
                    ram_addr_next    = base_reg + ADDR_WIDTH'(1);
                    ram_data_in_next = wdata_hi_reg[15:8];
                end else begin
                    state_next     = RSP;
                    rsp_valid_next = 1'b1;
                end
            end

            WR_B1: begin
                state_next       = WR_B2;
                ram_we_next      = WE_WRITE;
                ram_addr_next    = base_reg + ADDR_WIDTH'(2);
                ram_data_in_next = wdata_hi_reg[23:16];
            end

            WR_B2: begin
                state_next     = RSP;
                rsp_valid_next = 1'b1;
            end

            RSP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    cmd_ready_next = 1'b1;
                end else begin
                    rsp_valid_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            base_reg        <= '0;
            wdata_hi_reg    <= '0;
            len3_reg        <= 1'b0;
            cmd_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_err_reg     <= 1'b0;
            ram_addr_reg    <= '0;
            ram_data_in_reg <= 8'h00;
            ram_we_reg      <= WE_IDLE;
            err_sticky_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            base_reg        <= base_next;
            wdata_hi_reg    <= wdata_hi_next;
            len3_reg        <= len3_next;
            cmd_ready_reg   <= cmd_ready_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_err_reg     <= rsp_err_next;
            ram_addr_reg    <= ram_addr_next;
            ram_data_in_reg <= ram_data_in_next;
            ram_we_reg      <= ram_we_next;
            err_sticky_reg  <= err_sticky_next;
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_err     = rsp_err_reg;
    assign ram_addr    = ram_addr_reg;
    assign ram_data_in = ram_data_in_reg;
    assign ram_we      = ram_we_reg;
    assign err_sticky  = err_sticky_reg;

endmodule

// File: tb/tb_ram_access_master.sv
// Scoreboard bench for ram_access_master with a behavioural byte-RAM stub whose
// read latency is chosen per transaction, plus a separate reference byte store.
module tb_ram_access_master;

    localparam int AW   = 19;
    localparam int DW   = 24;
    localparam int TO   = 15;
    localparam int NMEM = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_len3;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data_in;
    logic [1:0]    ram_we;
    logic [DW-1:0] ram_data_out;
    logic          ram_ready;
    logic          err_sticky;

    int total = 0;
    int bad   = 0;

    ram_access_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_len3(cmd_len3), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_we(ram_we), .ram_data_out(ram_data_out), .ram_ready(ram_ready),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction

    // ---------------- RAM stub (driven only by the DUT pins) ----------------
    logic [7:0]    ram_mem [NMEM];
    bit            ram_wr  [NMEM];
    int            stub_lat = 6;     // 0 = never ready
    int            rd_cnt   = 0;
    logic          stray    = 1'b0;
    logic [AW-1:0] a1, a2;
    logic [7:0]    b0, b1, b2;

    always @(posedge clk) begin
        if (ram_we == 2'b10) begin
            ram_mem[ram_addr] <= ram_data_in;
            ram_wr[ram_addr]  <= 1'b1;
        end
        if (ram_we == 2'b01) rd_cnt <= rd_cnt + 1;
        else                 rd_cnt <= 0;
        stray <= ($urandom_range(0, 3) == 0);
    end

    assign a1 = ram_addr + AW'(1);
    assign a2 = ram_addr + AW'(2);
    assign b0 = ram_wr[ram_addr] ? ram_mem[ram_addr] : init_byte(ram_addr);
    assign b1 = ram_wr[a1] ? ram_mem[a1] : init_byte(a1);
    assign b2 = ram_wr[a2] ? ram_mem[a2] : init_byte(a2);
    assign ram_data_out = {b2, b1, b0};
    assign ram_ready = (ram_we == 2'b01) ? (stub_lat != 0 && rd_cnt == stub_lat - 1) : stray;

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [int];
    bit         sticky_model = 1'b0;

    function automatic logic [23:0] ref_read(input int a);
        logic [23:0] r;
        for (int i = 0; i < 3; i++) begin
            int idx;
            idx = (a + i) % NMEM;
            r[8*i +: 8] = ref_mem.exists(idx) ? ref_mem[idx] : init_byte(AW'(idx));
        end
        return r;
    endfunction

    typedef struct {
        logic [23:0] data;
        logic        err;
        int          lat;
        int          rd_cyc;
        int          wr_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cap_cyc = 0, rd_cyc = 0, wr_cyc = 0;
    bit seen = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen   = 1'b0;
                rd_cyc = 0;
                wr_cyc = 0;
            end else begin
                if (ram_we == 2'b01) rd_cyc++;
                if (ram_we == 2'b10) wr_cyc++;
                if (cmd_valid && cmd_ready) begin
                    cap_cyc = cyc;
                    rd_cyc  = 0;
                    wr_cyc  = 0;
                    seen    = 1'b0;
                end
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                    end else begin
                        if (!seen) begin
                            check("rsp_latency", 32'(cyc - cap_cyc), 32'(sb[0].lat));
                            check("we_read_cycles", 32'(rd_cyc), 32'(sb[0].rd_cyc));
                            check("we_write_cycles", 32'(wr_cyc), 32'(sb[0].wr_cyc));
                            seen = 1'b1;
                        end
                        check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                        check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                        check("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
                        check("rsp_ram_we", 32'(ram_we), 32'd0);
                        check("rsp_data_in", 32'(ram_data_in), 32'd0);
                        if (rsp_ready) begin
                            check("err_sticky", 32'(err_sticky), 32'(sticky_model));
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic wr, input logic l3, input int addr,
                         input logic [23:0] wd, input int lat, input int hold);
        exp_t e;
        bit   ok;
        int   nb;
        $display("txn %s len3=%0d addr=%05h wdata=%06h lat=%0d hold=%0d",
                 wr ? "WR" : "RD", l3, addr, wd, lat, hold);
        stub_lat  = lat;
        cmd_write = wr;
        cmd_len3  = l3;
        cmd_addr  = AW'(addr);
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 50 cycles");
            $fatal(1, "command not accepted");
        end
        if (wr) begin
            nb = l3 ? 3 : 1;
            for (int i = 0; i < nb; i++) ref_mem[(addr + i) % NMEM] = wd[8*i +: 8];
            e = '{data: 24'h0, err: 1'b0, lat: nb + 1, rd_cyc: 0, wr_cyc: nb};
        end else if (lat != 0 && lat <= TO) begin
            e = '{data: ref_read(addr), err: 1'b0, lat: lat + 2, rd_cyc: lat, wr_cyc: 0};
        end else begin
            e = '{data: 24'h0, err: 1'b1, lat: TO + 2, rd_cyc: TO, wr_cyc: 0};
            sticky_model = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk); #1 cmd_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            $display("FAIL rsp_wait: got rsp_valid=0 expected 1 within 60 cycles");
            $fatal(1, "response never arrived");
        end
        @(posedge clk); #1;
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int r, addr, lat;
        logic [23:0] wd;
        bit ok;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_len3 = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        #2;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_ram_we", 32'(ram_we), 32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'd0);
        check("reset_err_sticky", 32'(err_sticky), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // directed
        issue(1'b1, 1'b1, 32'h00010, 24'h332211, 6, 0);
        issue(1'b0, 1'b0, 32'h00010, 24'h0, 6, 0);
        issue(1'b1, 1'b1, 32'h00100, 24'hAABBCC, 6, 1);
        issue(1'b0, 1'b0, 32'h00100, 24'h0, 6, 0);
        issue(1'b1, 1'b1, 32'h7FFFF, 24'h123456, 6, 0);
        issue(1'b0, 1'b0, 32'h7FFFF, 24'h0, 6, 0);
        issue(1'b0, 1'b0, 32'h00000, 24'h0, 6, 0);
        issue(1'b1, 1'b0, 32'h00200, 24'h9988EE, 6, 0);
        issue(1'b0, 1'b0, 32'h001FF, 24'h0, 6, 0);
        issue(1'b0, 1'b0, 32'h00010, 24'h0, TO, 0);
        issue(1'b0, 1'b0, 32'h00010, 24'h0, 0, 0);
        issue(1'b0, 1'b0, 32'h00100, 24'h0, 6, 4);

        // reset during the third RD_WAIT cycle
        $display("txn RESET during read");
        stub_lat = 0; cmd_write = 1'b0; cmd_addr = AW'(32'h00100); cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        check("mid_reset_accept", 32'(ok), 32'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("mid_reset_ram_we", 32'(ram_we), 32'd0);
        check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_reset_err_sticky", 32'(err_sticky), 32'd0);
        sb.delete();
        sticky_model = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_reset_err_sticky", 32'(err_sticky), 32'd0);

        // randomized traffic
        for (int n = 0; n < 120; n++) begin
            r    = $urandom_range(0, 9);
            addr = ($urandom_range(0, 1) == 0) ? (32'h00100 + $urandom_range(0, 15))
                                               : (32'h7FFFC + $urandom_range(0, 3));
            wd   = 24'($urandom);
            lat  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 17) : 6;
            if (r < 4)      issue(1'b0, 1'b0, addr, 24'h0, lat, $urandom_range(0, 3));
            else if (r < 7) issue(1'b1, 1'b1, addr, wd, 6, $urandom_range(0, 3));
            else            issue(1'b1, 1'b0, addr, wd, 6, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
